// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B.
// One access in flight at a time, sequenced IDLE -> ISSUE -> CAPTURE.
module ram_arbiter #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDRESS_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0]    a_wdata,
  output logic                    a_grant,
  output logic                    a_done,
  output logic [DATA_BITS-1:0]    a_rdata,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDRESS_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0]    b_wdata,
  output logic                    b_grant,
  output logic                    b_done,
  output logic [DATA_BITS-1:0]    b_rdata,
  output logic                    ram_enable,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0]    ram_data_in,
  input  logic [DATA_BITS-1:0]    ram_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  // Requester identity encoding for last/owner: 0 = A, 1 = B.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t                  state, state_next;
  logic                    last, last_next;
  logic                    owner, owner_next;
  logic                    op_we, op_we_next;
  logic                    pick_b;
  logic                    a_grant_next, b_grant_next;
  logic                    a_done_next, b_done_next;
  logic                    ram_enable_next;
  logic [ADDRESS_BITS-1:0] ram_address_next;
  logic [DATA_BITS-1:0]    ram_data_in_next;
  logic [DATA_BITS-1:0]    a_rdata_next, b_rdata_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= SEL_B;
      owner       <= SEL_A;
      op_we       <= 1'b0;
      a_grant     <= 1'b0;
      b_grant     <= 1'b0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      ram_enable  <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      state       <= state_next;
      last        <= last_next;
      owner       <= owner_next;
      op_we       <= op_we_next;
      a_grant     <= a_grant_next;
      b_grant     <= b_grant_next;
      a_done      <= a_done_next;
      b_done      <= b_done_next;
      ram_enable  <= ram_enable_next;
      ram_address <= ram_address_next;
      ram_data_in <= ram_data_in_next;
      a_rdata     <= a_rdata_next;
      b_rdata     <= b_rdata_next;
    end
  end

  always_comb begin
    state_next       = state;
    last_next        = last;
    owner_next       = owner;
    op_we_next       = op_we;
    pick_b           = 1'b0;
    a_grant_next     = 1'b0;
    b_grant_next     = 1'b0;
    a_done_next      = 1'b0;
    b_done_next      = 1'b0;
    ram_enable_next  = 1'b0;
    ram_address_next = ram_address;
    ram_data_in_next = ram_data_in;
    a_rdata_next     = a_rdata;
    b_rdata_next     = b_rdata;

    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          // On a tie the requester not served last wins.
          pick_b           = b_req && (!a_req || (last == SEL_A));
          owner_next       = pick_b;
          last_next        = pick_b;
          op_we_next       = pick_b ? b_we : a_we;
          ram_enable_next  = pick_b ? b_we : a_we;
          ram_address_next = pick_b ? b_addr : a_addr;
          ram_data_in_next = pick_b ? b_wdata : a_wdata;
          a_grant_next     = !pick_b;
          b_grant_next     = pick_b;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        // RAM latches the command at the end of this cycle; enable drops next.
        state_next = CAPTURE;
      end
      CAPTURE: begin
        if (owner == SEL_B) begin
          b_done_next = 1'b1;
          if (!op_we) b_rdata_next = ram_data_out;
        end else begin
          a_done_next = 1'b1;
          if (!op_we) a_rdata_next = ram_data_out;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
